// File: rtl/pc_sequencer_if.sv
// pc_seq_if: control/observation bundle for pc_sequencer.
//   master: host/decode side. It drives the enable, stall, redirect, halt,
//           resume and step requests and observes the PC and status.
//   slave : the sequencer itself.
//   PC_WIDTH must match the PC_WIDTH of the pc_sequencer it is connected to.
interface pc_seq_if #(parameter int PC_WIDTH = 32);
  logic                enable;
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                halt;
  logic                resume;
  logic                step;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic                fetch_valid;
  logic                flush;
  logic                halted;
  logic [PC_WIDTH-1:0] update_count;

  modport master (
    output enable, stall, branch_taken, branch_target, jump, jump_target,
           halt, resume, step,
    input  pc_out, pc_plus1, fetch_valid, flush, halted, update_count
  );

  modport slave (
    input  enable, stall, branch_taken, branch_target, jump, jump_target,
           halt, resume, step,
    output pc_out, pc_plus1, fetch_valid, flush, halted, update_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and next-PC selection for the tp4 single-cycle
// datapath, with an IDLE/RUN/HALT run-control FSM and a saturating count of
// retired PC updates.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - pc_seq_if.slave
//           in : enable, stall, branch_taken/branch_target,
//                jump/jump_target, halt, resume, step
//           out: pc_out, pc_plus1, fetch_valid, flush, halted, update_count
//
// Parameters: PC_WIDTH (PC, target and counter width) and RESET_PC.
//
// Optional feature (compile-time macro PC_STEP_EN): when defined, step=1 in
// HALT performs one PC update and the FSM stays in HALT. When undefined, step
// is ignored.
module pc_sequencer #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [PC_WIDTH-1:0] ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] cnt_q, cnt_d;
  logic                flush_q, flush_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic                run_adv, step_adv, adv;

  // Advances from RUN and from single-step share the same next-PC mux.
  assign pc_inc  = pc_q + ONE;
  assign run_adv = (state_q == S_RUN) & bus.enable & ~bus.stall & ~bus.halt;
`ifdef PC_STEP_EN
  // resume outranks step. A stalled step does not move the PC.
  assign step_adv = (state_q == S_HALT) & bus.step & ~bus.resume & ~bus.stall;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign step_adv    = 1'b0;
`endif
  assign adv = run_adv | step_adv;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;

    if (adv) begin
      if (bus.jump)              pc_d = bus.jump_target;
      else if (bus.branch_taken) pc_d = bus.branch_target;
      else                       pc_d = pc_inc;
      flush_d = bus.jump | bus.branch_taken;
      if (cnt_q != '1) cnt_d = cnt_q + ONE;
    end

    case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_RUN;
      S_RUN:   if (bus.halt)   state_d = S_HALT;
      S_HALT:  if (bus.resume) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus1     = pc_inc;
  assign bus.fetch_valid  = adv;
  assign bus.flush        = flush_q;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.update_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int          W  = 32;
  localparam logic [31:0] RP = 32'h0;

  logic clk;
  logic reset;
  pc_seq_if #(.PC_WIDTH(W)) bus ();

  pc_sequencer #(.PC_WIDTH(W), .RESET_PC(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: run mode, PC, retired-update count, pending flush.
  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_e;
  mode_e       m_mode;
  logic [31:0] m_pc, m_cnt;
  logic        m_fl;
`ifdef PC_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // Current stimulus.
  logic        i_en, i_st, i_j, i_b, i_h, i_r, i_s;
  logic [31:0] i_jt, i_bt;

  task automatic set_in(input logic en, input logic st, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt, input logic h, input logic r,
                        input logic s);
    i_en = en; i_st = st; i_j = j; i_jt = jt; i_b = b; i_bt = bt; i_h = h; i_r = r; i_s = s;
    bus.enable = en; bus.stall = st; bus.jump = j; bus.jump_target = jt;
    bus.branch_taken = b; bus.branch_target = bt; bus.halt = h; bus.resume = r; bus.step = s;
  endtask

  function automatic logic m_moves();
    // The PC moves on a running, enabled, unstalled, non-halt cycle, or on a step
    // in HALT when stepping is built in (resume outranks step).
    return (m_mode == M_RUN && i_en && !i_st && !i_h) ||
           (STEP_EN && m_mode == M_HALT && i_s && !i_r && !i_st);
  endfunction

  task automatic m_edge();
    logic mv;
    mv   = m_moves();
    m_fl = mv && (i_j || i_b);
    if (mv) begin
      m_pc  = i_j ? i_jt : (i_b ? i_bt : m_pc + 32'd1);
      m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
    end
    case (m_mode)
      M_IDLE:  if (i_en) m_mode = M_RUN;
      M_RUN:   if (i_h)  m_mode = M_HALT;
      default: if (i_r)  m_mode = M_RUN;
    endcase
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_pc = RP; m_cnt = 0; m_fl = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pc_out"},       bus.pc_out,              m_pc);
    chk({tag, ".flush"},        32'(bus.flush),          32'(m_fl));
    chk({tag, ".halted"},       32'(bus.halted),         32'(m_mode == M_HALT));
    chk({tag, ".update_count"}, bus.update_count,        m_cnt);
  endtask

  // One model-checked cycle. It starts just after an edge and ends #1 after the next one.
  task automatic run_cycle(input string tag);
    #1;
    chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(m_moves()));
    chk({tag, ".pc_plus1"},    bus.pc_plus1,         m_pc + 32'd1);
    @(posedge clk);
    m_edge();
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic en, st, j; logic [31:0] jt; logic b; logic [31:0] bt; logic h, r;
    logic [31:0] e_pc; logic e_fl, e_hl; logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl[20];

  initial begin
    // Expected values are written out per cycle, starting from reset.
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h0,       1'b0,1'b0, 32'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h1,       1'b0,1'b0, 32'd1};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h2,       1'b0,1'b0, 32'd2};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h3,       1'b0,1'b0, 32'd3};
    tbl[4]  = '{1'b1,1'b0,1'b1,32'h10,      1'b0,32'h0, 1'b0,1'b0, 32'h10,      1'b1,1'b0, 32'd4};
    tbl[5]  = '{1'b1,1'b0,1'b1,32'h80,      1'b1,32'h40,1'b0,1'b0, 32'h80,      1'b1,1'b0, 32'd5};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h81,      1'b0,1'b0, 32'd6};
    tbl[7]  = '{1'b1,1'b0,1'b1,32'hFFFFFFFF,1'b0,32'h0, 1'b0,1'b0, 32'hFFFFFFFF,1'b1,1'b0, 32'd7};
    tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h0,       1'b0,1'b0, 32'd8};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,       1'b1,32'h20,1'b0,1'b0, 32'h20,      1'b1,1'b0, 32'd9};
    tbl[10] = '{1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h20,      1'b0,1'b0, 32'd9};
    tbl[11] = '{1'b1,1'b1,1'b1,32'h99,      1'b0,32'h0, 1'b0,1'b0, 32'h20,      1'b0,1'b0, 32'd9};
    tbl[12] = '{1'b1,1'b1,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h20,      1'b0,1'b0, 32'd9};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,32'h30,1'b0,1'b0, 32'h30,      1'b1,1'b0, 32'd10};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h0,       1'b1,32'h55,1'b1,1'b0, 32'h30,      1'b0,1'b1, 32'd10};
    tbl[15] = '{1'b1,1'b0,1'b1,32'h77,      1'b0,32'h0, 1'b1,1'b0, 32'h30,      1'b0,1'b1, 32'd10};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b1, 32'h30,      1'b0,1'b0, 32'd10};
    tbl[17] = '{1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h31,      1'b0,1'b0, 32'd11};
    tbl[18] = '{1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0, 1'b0,1'b0, 32'h31,      1'b0,1'b0, 32'd11};
    tbl[19] = '{1'b0,1'b0,1'b1,32'h44,      1'b0,32'h0, 1'b0,1'b0, 32'h31,      1'b0,1'b0, 32'd11};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset.pc_out",       bus.pc_out,              RP);
    chk("reset.flush",        32'(bus.flush),          32'd0);
    chk("reset.halted",       32'(bus.halted),         32'd0);
    chk("reset.update_count", bus.update_count,        32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("idle.fetch_valid",   32'(bus.fetch_valid),    32'd0);

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].en, tbl[i].st, tbl[i].j, tbl[i].jt, tbl[i].b, tbl[i].bt, tbl[i].h, tbl[i].r, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.pc_out", i),       bus.pc_out,          tbl[i].e_pc);
      chk($sformatf("vec%0d.flush", i),        32'(bus.flush),      32'(tbl[i].e_fl));
      chk($sformatf("vec%0d.halted", i),       32'(bus.halted),     32'(tbl[i].e_hl));
      chk($sformatf("vec%0d.update_count", i), bus.update_count,    tbl[i].e_cnt);
    end

    // Halt and single-step corner cases, followed by a reset issued mid-HALT.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);           run_cycle("hs.go");
    set_in(1, 0, 1, 32'h50, 0, 0, 0, 0, 0);      run_cycle("hs.jmp");
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);           run_cycle("hs.halt");
    chk("hs.halted_at_50", bus.pc_out, 32'h50);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);           run_cycle("hs.step");
`ifdef PC_STEP_EN
    chk("hs.step_pc", bus.pc_out, 32'h51);
    chk("hs.step_halted", 32'(bus.halted), 32'd1);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 1);           run_cycle("hs.step_stall");
    chk("hs.step_stall_pc", bus.pc_out, 32'h51);
    set_in(0, 0, 1, 32'h70, 1, 32'h60, 0, 0, 1); run_cycle("hs.step_jmp");
    chk("hs.step_jmp_pc", bus.pc_out, 32'h70);
    chk("hs.step_jmp_flush", 32'(bus.flush), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);           run_cycle("hs.resume_over_step");
    chk("hs.resume_pc", bus.pc_out, 32'h70);
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);           run_cycle("hs.halt2");
`else
    chk("hs.step_ignored_pc", bus.pc_out, 32'h50);
    chk("hs.step_ignored_halted", 32'(bus.halted), 32'd1);
`endif
    // Raise reset in the middle of the cycle and check it before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async.pc_out",       bus.pc_out,           RP);
    chk("async.halted",       32'(bus.halted),      32'd0);
    chk("async.update_count", bus.update_count,     32'd0);
    chk("async.flush",        32'(bus.flush),       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();

    // Randomized stimulus checked against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] jt, bt;
      jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bt = $urandom;
      set_in(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 5) == 0), jt, 1'($urandom_range(0, 4) == 0), bt,
             1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0));
      run_cycle($sformatf("rnd%0d", i));
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
